calc_operand_entry: RTL and testbench

//  Operand source for the 4-bit adder/subtractor calculator on DE10-Lite.

---
 rtl/calc_operand_entry_pkg.sv | 29 ++
 rtl/calc_operand_entry_key_debounce.sv | 56 +++++
 rtl/calc_operand_entry.sv | 112 +++++++++++
 tb/tb_calc_operand_entry.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_operand_entry_pkg.sv
// Shared types and constants for the calculator operand-entry block.
// The op encodings are also used by the adder/subtractor top.
package calc_operand_entry_pkg;

   typedef enum logic [1:0] {
      ENTER_A  = 2'd0,
      ENTER_B  = 2'd1,
      ENTER_OP = 2'd2,
      SHOW     = 2'd3
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // One-hot LED pattern for the step the operator is currently on; dark once the entry is shown.
   function automatic logic [2:0] step_decode(input state_t st);
      logic [2:0] led;
      led = 3'b000;
      case (st)
         ENTER_A:  led = 3'b001;
         ENTER_B:  led = 3'b010;
         ENTER_OP: led = 3'b100;
         SHOW:     led = 3'b000;
         default:  led = 3'b000;
      endcase
      return led;
   endfunction

endpackage

// File: rtl/calc_operand_entry_key_debounce.sv
// Debouncer for one active-low push button: 2-flop synchroniser, stability counter,
// and a single-cycle pulse on each accepted press (debounced 1->0).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt;

   // Released (1) is the safe idle level, so a key held through reset still yields one press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= key;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= 1'b1;
         cnt     <= '0;
      end else if (sync_q2 == level_q) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         level_q <= sync_q2;
         cnt     <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b1;
         press   <= 1'b0;
      end else begin
         level_d <= level_q;
         press   <= level_d & ~level_q;
      end
   end

endmodule

// File: rtl/calc_operand_entry.sv
// Operand entry for the 4-bit adder/subtractor: KEY0 steps through A, B and op capture,
// KEY1 clears the entry. Drives a0/a1/s and a valid flag for the display.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ENTER_A  | waiting for enter to capture sw into a0
//   ENTER_B  | waiting for enter to capture sw into a1
//   ENTER_OP | waiting for enter to capture sw_op into s
//   SHOW     | entry complete, valid high; enter starts over
module calc_operand_entry
   import calc_operand_entry_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             sw_op,
   input  logic             key_enter,
   input  logic             key_clear,
   output logic [WIDTH-1:0] a0,
   output logic [WIDTH-1:0] a1,
   output logic             s,
   output logic             valid,
   output logic [2:0]       step
);

   state_t state;
   state_t state_nxt;
   logic   enter_p;
   logic   clear_p;
   logic   cap_a0;
   logic   cap_a1;
   logic   cap_s;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
      .clk   (clk),
      .rst   (rst),
      .key   (key_enter),
      .press (enter_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk   (clk),
      .rst   (rst),
      .key   (key_clear),
      .press (clear_p)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ENTER_A;
      end else begin
         state <= state_nxt;
      end
   end

   // Clear has priority; a coincident enter pulse is dropped.
   always_comb begin
      state_nxt = state;
      if (clear_p) begin
         state_nxt = ENTER_A;
      end else if (enter_p) begin
         unique case (state)
            ENTER_A:  state_nxt = ENTER_B;
            ENTER_B:  state_nxt = ENTER_OP;
            ENTER_OP: state_nxt = SHOW;
            SHOW:     state_nxt = ENTER_A;
            default:  state_nxt = ENTER_A;
         endcase
      end
   end

   always_comb begin
      cap_a0 = 1'b0;
      cap_a1 = 1'b0;
      cap_s  = 1'b0;
      step   = step_decode(state);
      if (enter_p && !clear_p) begin
         unique case (state)
            ENTER_A:  cap_a0 = 1'b1;
            ENTER_B:  cap_a1 = 1'b1;
            ENTER_OP: cap_s  = 1'b1;
            SHOW:     cap_s  = 1'b0;
            default:  cap_s  = 1'b0;
         endcase
      end
   end

   // sw is quasi-static and sampled directly; leaving SHOW keeps the last operands visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a0    <= '0;
         a1    <= '0;
         s     <= OP_ADD;
         valid <= 1'b0;
      end else begin
         if (clear_p) begin
            a0 <= '0;
            a1 <= '0;
            s  <= OP_ADD;
         end else begin
            if (cap_a0) a0 <= sw;
            if (cap_a1) a1 <= sw;
            if (cap_s)  s  <= sw_op;
         end
         valid <= (state_nxt == SHOW);
      end
   end

endmodule

// File: tb/tb_calc_operand_entry.sv
// Scenario bench for calc_operand_entry with a short debounce window.
module tb_calc_operand_entry;
   import calc_operand_entry_pkg::*;

   localparam int W = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw = '0;
   logic         sw_op = 1'b0;
   logic         key_enter = 1'b1;
   logic         key_clear = 1'b1;
   logic [W-1:0] a0;
   logic [W-1:0] a1;
   logic         s;
   logic         valid;
   logic [2:0]   step;

   calc_operand_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .sw_op     (sw_op),
      .key_enter (key_enter),
      .key_clear (key_clear),
      .a0        (a0),
      .a1        (a1),
      .s         (s),
      .valid     (valid),
      .step      (step)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail = 0;
   logic [12:0]  sb[$];
   logic [12:0]  exp_v;
   int           m_st = 0;
   logic [W-1:0] m_a0 = '0;
   logic [W-1:0] m_a1 = '0;
   logic         m_s = 1'b0;

   function automatic logic [2:0] m_step(input int st);
      case (st)
         0: return 3'b001;
         1: return 3'b010;
         2: return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [12:0] m_pack();
      return {m_a0, m_a1, m_s, (m_st == 3), m_step(m_st)};
   endfunction

   function automatic logic [12:0] obs();
      return {a0, a1, s, valid, step};
   endfunction

   task automatic model_enter(input logic [W-1:0] swv, input logic opv);
      case (m_st)
         0: begin m_a0 = swv; m_st = 1; end
         1: begin m_a1 = swv; m_st = 2; end
         2: begin m_s = opv;  m_st = 3; end
         default: m_st = 0;
      endcase
      sb.push_back(m_pack());
   endtask

   task automatic model_clear();
      m_st = 0; m_a0 = '0; m_a1 = '0; m_s = 1'b0;
      sb.push_back(m_pack());
   endtask

   // Drive one full press/release of enter and/or clear; returns on a falling edge.
   task automatic press(input bit ent, input bit clr, input logic [W-1:0] swv, input logic opv);
      @(negedge clk);
      sw = swv; sw_op = opv;
      if (ent) key_enter = 1'b0;
      if (clr) key_clear = 1'b0;
      repeat (D + 8) @(negedge clk);
      key_enter = 1'b1; key_clear = 1'b1;
      repeat (D + 8) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      model_clear();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_held: got %h want %h", obs(), exp_v); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs() !== m_pack()) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs(), m_pack()); end
   endtask

   task automatic test_add();
      logic [W-1:0] vals[3];
      logic         ops[3];
      vals = '{4'd5, 4'd2, 4'd0};
      ops  = '{1'b1, 1'b1, OP_ADD};
      for (int i = 0; i < 3; i++) begin
         press(1, 0, vals[i], ops[i]);
         model_enter(vals[i], ops[i]);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs() !== exp_v) begin n_fail++; $display("FAIL add_step%0d: got %h want %h", i, obs(), exp_v); end
      end
      n_checks++;
      if (({1'b0, a0} + {1'b0, a1}) !== 5'd7) begin n_fail++; $display("FAIL add_sum: got %0d want 7", {1'b0, a0} + {1'b0, a1}); end
   endtask

   task automatic test_carry();
      logic [W-1:0] vals[8];
      logic         ops[8];
      vals = '{4'd0, 4'd8, 4'd9, 4'd0, 4'd0, 4'd8, 4'd3, 4'd0};
      ops  = '{1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, OP_SUB};
      for (int i = 0; i < 8; i++) begin
         press(1, 0, vals[i], ops[i]);
         model_enter(vals[i], ops[i]);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs() !== exp_v) begin n_fail++; $display("FAIL carry_step%0d: got %h want %h", i, obs(), exp_v); end
         if (i == 3) begin
            n_checks++;
            if (({1'b0, a0} + {1'b0, a1}) !== 5'd17) begin n_fail++; $display("FAIL carry_sum: got %0d want 17", {1'b0, a0} + {1'b0, a1}); end
         end
      end
      n_checks++;
      if ((a0 - a1) !== 4'd5) begin n_fail++; $display("FAIL sub_diff: got %0d want 5", a0 - a1); end
   endtask

   task automatic test_bounce();
      press(0, 1, 4'd0, 1'b0);
      model_clear();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL bounce_clear: got %h want %h", obs(), exp_v); end
      @(negedge clk); sw = 4'hA; key_enter = 1'b0;
      @(negedge clk); key_enter = 1'b1;
      @(negedge clk); key_enter = 1'b0;
      @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (obs() !== m_pack()) begin n_fail++; $display("FAIL bounce_early: got %h want %h", obs(), m_pack()); end
      model_enter(4'hA, 1'b0);
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL bounce_capture: got %h want %h", obs(), exp_v); end
      repeat (100) @(negedge clk);
      n_checks++;
      if (obs() !== m_pack()) begin n_fail++; $display("FAIL bounce_hold: got %h want %h", obs(), m_pack()); end
      key_enter = 1'b1;
      repeat (D + 8) @(negedge clk);
   endtask

   task automatic test_clear();
      press(0, 1, 4'd0, 1'b0);
      model_clear();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL clear_pre: got %h want %h", obs(), exp_v); end
      press(1, 0, 4'd3, 1'b0); model_enter(4'd3, 1'b0);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL clear_a: got %h want %h", obs(), exp_v); end
      press(1, 0, 4'd5, 1'b0); model_enter(4'd5, 1'b0);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL clear_b: got %h want %h", obs(), exp_v); end
      press(1, 1, 4'd9, 1'b1); model_clear();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL clear_wins: got %h want %h", obs(), exp_v); end
   endtask

   task automatic test_reset_mid();
      press(1, 0, 4'd7, 1'b0); model_enter(4'd7, 1'b0);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL rstmid_pre: got %h want %h", obs(), exp_v); end
      @(negedge clk); sw = 4'd6; key_enter = 1'b0;
      @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      model_clear();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL rstmid_reset: got %h want %h", obs(), exp_v); end
      @(negedge clk); rst = 1'b0;
      repeat (D + 8) @(negedge clk);
      model_enter(4'd6, 1'b0);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL rstmid_press: got %h want %h", obs(), exp_v); end
      key_enter = 1'b1;
      repeat (D + 8) @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [W-1:0] vals[3];
      logic         ops[3];
      vals = '{4'd1, 4'd0, 4'hF};
      ops  = '{1'b0, OP_SUB, 1'b0};
      for (int i = 0; i < 3; i++) begin
         press(1, 0, vals[i], ops[i]);
         model_enter(vals[i], ops[i]);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs() !== exp_v) begin n_fail++; $display("FAIL wrap_step%0d: got %h want %h", i, obs(), exp_v); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry();
      test_bounce();
      test_clear();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule
